// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mip/mie/mstatus/mtvec/mepc/mcause,
// interrupt-take decision and fetch redirect handshake for trap and mret.
module irq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  timer_irq_i,
  input  logic                  software_irq_i,
  input  logic                  external_irq_i,
  input  logic                  csr_we_i,
  input  logic [11:0]           csr_addr_i,
  input  logic [DATA_WIDTH-1:0] csr_wdata_i,
  output logic [DATA_WIDTH-1:0] csr_rdata_o,
  input  logic                  inst_valid_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  mret_i,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o,
  input  logic                  redirect_ack_i
);

  localparam int W = DATA_WIDTH;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [W-1:0] MIE_MASK = {{(W-12){1'b0}}, 12'h888};
  localparam logic [W-1:0] TVEC_MASK = ~{{(W-2){1'b0}}, 2'b10};
  localparam logic [W-1:0] EPC_MASK = ~{{(W-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRAP = 2'd1,
    MRET = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic         st_mie_q, st_mie_d;
  logic         st_mpie_q, st_mpie_d;
  logic [W-1:0] mie_q, mie_d;
  logic [W-1:0] mtvec_q, mtvec_d;
  logic [W-1:0] mepc_q, mepc_d;
  logic [W-1:0] mcause_q, mcause_d;
  logic [W-1:0] mip_q, mip_d;
  logic [W-1:0] rpc_q, rpc_d;

  logic [W-1:0] pending;
  logic [3:0]   code;
  logic         idle;
  logic         take;
  logic         mret_go;

  assign idle    = (state_q == IDLE);
  assign pending = mip_q & mie_q;
  assign take    = idle & st_mie_q & (|pending)
                 & inst_valid_i & ~mret_i;
  assign mret_go = idle & mret_i;

  // MEI > MSI > MTI
  always_comb begin
    code = 4'd0;
    if (pending[11])     code = 4'd11;
    else if (pending[3]) code = 4'd3;
    else if (pending[7]) code = 4'd7;
  end

  always_comb begin
    mip_d     = '0;
    mip_d[3]  = software_irq_i;
    mip_d[7]  = timer_irq_i;
    mip_d[11] = external_irq_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mret_go)   state_d = MRET;
        else if (take) state_d = TRAP;
      end
      TRAP, MRET: begin
        if (redirect_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_o    = (state_q != IDLE);
    redirect_pc_o = rpc_q;
  end

  // Software writes first; trap/mret hardware updates override them.
  always_comb begin
    st_mie_d  = st_mie_q;
    st_mpie_d = st_mpie_q;
    mie_d     = mie_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    rpc_d     = rpc_q;
    if (csr_we_i) begin
      case (csr_addr_i)
        A_MSTATUS: begin
          st_mie_d  = csr_wdata_i[3];
          st_mpie_d = csr_wdata_i[7];
        end
        A_MIE:    mie_d    = csr_wdata_i & MIE_MASK;
        A_MTVEC:  mtvec_d  = csr_wdata_i & TVEC_MASK;
        A_MEPC:   mepc_d   = csr_wdata_i & EPC_MASK;
        A_MCAUSE: mcause_d = csr_wdata_i;
        default: ;
      endcase
    end
    if (take) begin
      mepc_d    = pc_i & EPC_MASK;
      mcause_d  = {1'b1, {(W-5){1'b0}}, code};
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
      rpc_d     = {mtvec_q[W-1:2], 2'b00}
                + (mtvec_q[0] ? {{(W-6){1'b0}}, code, 2'b00}
                              : '0);
    end else if (mret_go) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
      rpc_d     = mepc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      mie_q     <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mip_q     <= '0;
      rpc_q     <= '0;
    end else begin
      st_mie_q  <= st_mie_d;
      st_mpie_q <= st_mpie_d;
      mie_q     <= mie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mip_q     <= mip_d;
      rpc_q     <= rpc_d;
    end
  end

  always_comb begin
    csr_rdata_o = '0;
    case (csr_addr_i)
      A_MSTATUS: begin
        csr_rdata_o[12:11] = 2'b11;
        csr_rdata_o[7]     = st_mpie_q;
        csr_rdata_o[3]     = st_mie_q;
      end
      A_MIE:    csr_rdata_o = mie_q;
      A_MTVEC:  csr_rdata_o = mtvec_q;
      A_MEPC:   csr_rdata_o = mepc_q;
      A_MCAUSE: csr_rdata_o = mcause_q;
      A_MIP:    csr_rdata_o = mip_q;
      default:  csr_rdata_o = '0;
    endcase
  end

endmodule
